mul_seq64: RTL and testbench

- Sequential radix-4 shift-add integer multiplier for the River integer pipeline.
- Computes RV64M MUL, MULH, MULHSU, MULHU and MULW.
- Datapath is the mirror of the restoring divider: conditional add-and-shift of the multiplicand, instead of subtract-and-shift of the divisor.
- Sits beside the divider in the arith unit and uses the same start/valid handshake.

---
 rtl/mul_seq64.sv | 146 ++++++++++++++
 tb/tb_mul_seq64.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq64.sv
// Sequential radix-4 shift-add multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW.
// Two multiplier bits are retired per cycle on unsigned magnitudes; the sign
// is restored by a single 128-bit negation in the FIX state.
module mul_seq64 (
   input  logic        i_clk,
   input  logic        i_nrst,
   input  logic        i_ena,
   input  logic [2:0]  i_mode,
   input  logic [63:0] i_a1,
   input  logic [63:0] i_a2,
   output logic        o_ready,
   output logic        o_valid,
   output logic [63:0] o_res
);

   localparam int unsigned XLEN = 64;
   localparam int unsigned AW   = 128;
   localparam int unsigned CW   = 5;
   localparam int unsigned WLEN = 32;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   typedef enum logic [1:0] {SEL_LO, SEL_HI, SEL_W} sel_t;

   state_t          state;
   sel_t            sel;
   logic [AW-1:0]   acc;
   logic [AW-1:0]   mcand;
   logic [XLEN-1:0] mplier;
   logic [CW-1:0]   cnt;
   logic            neg;

   logic            a_signed;
   logic            b_signed;
   logic            is_w;
   sel_t            sel_c;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_abs;
   logic [XLEN-1:0] b_abs;
   logic [AW-1:0]   addend;
   logic [AW-1:0]   acc_sum;
   logic [AW-1:0]   acc_fix;

   // Mode decode and operand magnitudes for the capture edge
   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      is_w     = 1'b0;
      sel_c    = SEL_LO;
      case (i_mode)
         3'b001: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
            sel_c    = SEL_HI;
         end
         3'b010: begin
            a_signed = 1'b1;
            sel_c    = SEL_HI;
         end
         3'b011: sel_c = SEL_HI;
         3'b100: begin
            is_w  = 1'b1;
            sel_c = SEL_W;
         end
         default: sel_c = SEL_LO;
      endcase
      a_neg = a_signed & i_a1[XLEN-1];
      b_neg = b_signed & i_a2[XLEN-1];
      if (is_w) begin
         a_abs = {WLEN'(0), i_a1[WLEN-1:0]};
         b_abs = {WLEN'(0), i_a2[WLEN-1:0]};
      end else begin
         a_abs = a_neg ? XLEN'(~i_a1 + XLEN'(1)) : i_a1;
         b_abs = b_neg ? XLEN'(~i_a2 + XLEN'(1)) : i_a2;
      end
   end

   // Radix-4 partial product selection, accumulation and final sign fix
   always_comb begin
      case (mplier[1:0])
         2'b01:   addend = mcand;
         2'b10:   addend = AW'(mcand << 1);
         2'b11:   addend = AW'(mcand + AW'(mcand << 1));
         default: addend = '0;
      endcase
      acc_sum = AW'(acc + addend);
      acc_fix = neg ? AW'(~acc + AW'(1)) : acc;
   end

   // Control FSM and datapath registers
   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         state   <= IDLE;
         sel     <= SEL_LO;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
         neg     <= 1'b0;
         o_ready <= 1'b1;
         o_valid <= 1'b0;
         o_res   <= '0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_ena) begin
                  mcand   <= {XLEN'(0), a_abs};
                  mplier  <= b_abs;
                  acc     <= '0;
                  neg     <= a_neg ^ b_neg;
                  sel     <= sel_c;
                  cnt     <= is_w ? CW'(15) : CW'(31);
                  o_ready <= 1'b0;
                  state   <= CALC;
               end
            end
            CALC: begin
               acc    <= acc_sum;
               mcand  <= AW'(mcand << 2);
               mplier <= mplier >> 2;
               cnt    <= CW'(cnt - CW'(1));
               if (cnt == '0) begin
                  state <= FIX;
               end
            end
            FIX: begin
               case (sel)
                  SEL_HI:  o_res <= acc_fix[AW-1:XLEN];
                  SEL_W:   o_res <= {{WLEN{acc_fix[WLEN-1]}}, acc_fix[WLEN-1:0]};
                  default: o_res <= acc_fix[XLEN-1:0];
               endcase
               acc     <= acc_fix;
               o_valid <= 1'b1;
               o_ready <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               o_ready <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_seq64.sv
// Directed-vector and control-sequence bench for mul_seq64.
module tb_mul_seq64;

   logic        clk;
   logic        nrst;
   logic        ena;
   logic [2:0]  mode;
   logic [63:0] a1;
   logic [63:0] a2;
   logic        ready;
   logic        valid;
   logic [63:0] res;

   int tests;
   int fails;

   typedef struct {
      logic [2:0]  mode;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   mul_seq64 dut (
      .i_clk   (clk),
      .i_nrst  (nrst),
      .i_ena   (ena),
      .i_mode  (mode),
      .i_a1    (a1),
      .i_a2    (a2),
      .o_ready (ready),
      .o_valid (valid),
      .o_res   (res)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b);
      logic [127:0] ea, eb, p;
      logic [63:0]  pw;
      ea = {64'd0, a};
      eb = {64'd0, b};
      case (m)
         3'b001: begin
            ea = {{64{a[63]}}, a};
            eb = {{64{b[63]}}, b};
         end
         3'b010: ea = {{64{a[63]}}, a};
         default: ;
      endcase
      p = ea * eb;
      pw = {32'd0, a[31:0]} * {32'd0, b[31:0]};
      case (m)
         3'b001, 3'b010, 3'b011: return p[127:64];
         3'b100: return {{32{pw[31]}}, pw[31:0]};
         default: return p[63:0];
      endcase
   endfunction

   // Present one start request; the following posedge is E0
   task automatic start(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      ena  = 1'b1;
      mode = m;
      a1   = a;
      a2   = b;
      @(posedge clk);
      #1;
      ena = 1'b0;
      a1  = ~a;
      a2  = ~b;
      mode = 3'b011;
   endtask

   // Wait for o_valid; lat counts edges from E0 inclusive; optional stray i_ena at cycle pulse_at
   task automatic wait_valid(input int pulse_at, output logic [63:0] r, output int lat, output bit ready_low);
      lat = 1;
      ready_low = 1'b1;
      r = 'x;
      while (1) begin
         if (pulse_at != 0 && lat == pulse_at) begin
            @(negedge clk);
            ena = 1'b1;
            mode = 3'b000;
            a1 = 64'd100;
            a2 = 64'd100;
         end
         @(posedge clk);
         lat++;
         #1;
         ena = 1'b0;
         if (valid) begin
            r = res;
            break;
         end
         if (ready) ready_low = 1'b0;
         if (lat > 200) begin
            tests++;
            fails++;
            $display("FAIL timeout: got no o_valid expected one within 200 cycles");
            break;
         end
      end
   endtask

   logic [63:0] r;
   int          lat;
   bit          rl;
   bit          seen;

   initial begin
      tests = 0;
      fails = 0;
      nrst = 1'b0;
      ena  = 1'b0;
      mode = '0;
      a1   = '0;
      a2   = '0;

      vecs.push_back('{3'b000, 64'd3, 64'd5, 64'h0000_0000_0000_000F, 34});
      vecs.push_back('{3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 34});
      vecs.push_back('{3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 34});
      vecs.push_back('{3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 34});
      vecs.push_back('{3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 34});
      vecs.push_back('{3'b100, 64'h7FFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFE, 18});
      vecs.push_back('{3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 34});
      vecs.push_back('{3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 34});
      vecs.push_back('{3'b001, 64'h8000_0000_0000_0000, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 34});
      vecs.push_back('{3'b001, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3, 64'hFFFF_FFFF_FFFF_FFFF, 34});
      vecs.push_back('{3'b010, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 34});
      vecs.push_back('{3'b011, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1, 34});
      vecs.push_back('{3'b100, 64'hDEAD_0000_0000_0003, 64'hBEEF_0000_0000_0004, 64'hC, 18});
      vecs.push_back('{3'b100, 64'h0, 64'h5, 64'h0, 18});
      vecs.push_back('{3'b111, 64'd3, 64'd5, 64'hF, 34});
      vecs.push_back('{3'b000, 64'h0, 64'h0, 64'h0, 34});

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", 64'(ready), 64'd1);
      check("reset_valid", 64'(valid), 64'd0);
      check("reset_res", res, 64'd0);
      @(negedge clk);
      nrst = 1'b1;

      // Directed table
      foreach (vecs[i]) begin
         start(vecs[i].mode, vecs[i].a, vecs[i].b);
         wait_valid(0, r, lat, rl);
         check($sformatf("vec%0d_res", i), r, vecs[i].exp);
         check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
         check($sformatf("vec%0d_ready_low", i), 64'(rl), 64'd1);
      end

      // Stray start at cycle 10 is ignored; back-to-back start in o_valid cycle accepted
      start(3'b000, 64'd7, 64'd9);
      wait_valid(10, r, lat, rl);
      check("ctl_res", r, 64'd63);
      check("ctl_lat", 64'(lat), 64'd34);
      check("ctl_ready_in_valid", 64'(ready), 64'd1);
      start(3'b000, 64'd11, 64'd13);
      check("b2b_valid_drop", 64'(valid), 64'd0);
      check("b2b_ready_low", 64'(ready), 64'd0);
      check("b2b_res_held", res, 64'd63);
      wait_valid(0, r, lat, rl);
      check("b2b_res", r, 64'd143);
      check("b2b_lat", 64'(lat), 64'd34);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (valid || !ready) seen = 1'b1;
      end
      check("no_queued_op", 64'(seen), 64'd0);
      check("res_held_idle", res, 64'd143);

      // Reset mid-operation aborts
      start(3'b000, 64'd5, 64'd6);
      repeat (19) @(posedge clk);
      @(negedge clk);
      nrst = 1'b0;
      @(posedge clk);
      #1;
      check("abort_ready", 64'(ready), 64'd1);
      check("abort_res", res, 64'd0);
      @(negedge clk);
      nrst = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (valid) seen = 1'b1;
      end
      check("abort_no_valid", 64'(seen), 64'd0);

      // Random operands and modes against the reference model
      for (int k = 0; k < 300; k++) begin
         logic [2:0]  m;
         logic [63:0] ra, rb;
         m  = 3'($urandom_range(0, 7));
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         if (k % 10 == 0) ra = 64'h8000_0000_0000_0000;
         start(m, ra, rb);
         wait_valid(0, r, lat, rl);
         check($sformatf("rnd%0d_m%0d_%h_%h", k, m, ra, rb), r, ref_mul(m, ra, rb));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
